// File: rtl/camera_pkg.sv
// Shared camera-control types: arbiter state encoding, I2C word width and timeout default.
package camera_pkg;

  localparam int          I2C_WORD_W      = 32;
  localparam logic [15:0] TIMEOUT_CYC_DEF = 16'd50000;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_DROP     = 3'd3,
    ST_DONE     = 3'd4
  } arb_state_t;

  // Round-robin choice: on contention the requester that did not go last wins.
  function automatic logic rr_pick(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return ~last;
    return r1;
  endfunction

endpackage

// File: rtl/i2c_arbiter_if.sv
// Bundle of the two requester handshakes, the shared send_i2c engine port and arbiter status.
interface i2c_arbiter_if;
  import camera_pkg::*;

  logic                  req0_req;
  logic [I2C_WORD_W-1:0] req0_data;
  logic                  req0_ack;
  logic                  req0_err;
  logic                  req1_req;
  logic [I2C_WORD_W-1:0] req1_data;
  logic                  req1_ack;
  logic                  req1_err;
  logic                  i2c_req;
  logic [I2C_WORD_W-1:0] i2c_data;
  logic                  i2c_ack;
  logic                  busy;
  logic                  grant;

  modport slave (
    input  req0_req, req0_data, req1_req, req1_data, i2c_ack,
    output req0_ack, req0_err, req1_ack, req1_err, i2c_req, i2c_data, busy, grant
  );

  modport master (
    output req0_req, req0_data, req1_req, req1_data, i2c_ack,
    input  req0_ack, req0_err, req1_ack, req1_err, i2c_req, i2c_data, busy, grant
  );

endinterface

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one send_i2c engine between two requesters; i2c_req rises 2 cycles
// after a request is sampled, ack is held until the owner drops req, a stalled engine times out.
module i2c_arbiter
  import camera_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic         clk_25M,
  input  logic         rst_100,
  i2c_arbiter_if.slave bus
);

  arb_state_t            state, state_nxt;
  logic [15:0]           tmo_cnt, tmo_cnt_nxt;
  logic                  i2c_req_q, i2c_req_nxt;
  logic [I2C_WORD_W-1:0] i2c_data_q, i2c_data_nxt;
  logic                  grant_q, grant_nxt;
  logic                  last_grant, last_grant_nxt;
  logic                  err_q, err_nxt;
  logic                  any_req;
  logic                  own_req;
  logic                  tmo_hit;

  assign any_req = bus.req0_req || bus.req1_req;
  assign own_req = grant_q ? bus.req1_req : bus.req0_req;
  assign tmo_hit = (tmo_cnt == TIMEOUT_CYC - 16'd1);

  always_ff @(posedge clk_25M) begin
    if (rst_100) begin
      state      <= ST_IDLE;
      tmo_cnt    <= '0;
      i2c_req_q  <= 1'b0;
      i2c_data_q <= '0;
      grant_q    <= 1'b0;
      last_grant <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      tmo_cnt    <= tmo_cnt_nxt;
      i2c_req_q  <= i2c_req_nxt;
      i2c_data_q <= i2c_data_nxt;
      grant_q    <= grant_nxt;
      last_grant <= last_grant_nxt;
      err_q      <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (any_req) state_nxt = ST_LOAD;
      ST_LOAD:     state_nxt = ST_WAIT_ACK;
      // A late ack on the timeout cycle still counts as a clean completion.
      ST_WAIT_ACK: begin
        if (bus.i2c_ack)  state_nxt = ST_DROP;
        else if (tmo_hit) state_nxt = ST_DONE;
      end
      ST_DROP:     if (!bus.i2c_ack || tmo_hit) state_nxt = ST_DONE;
      ST_DONE:     if (!own_req) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    tmo_cnt_nxt    = tmo_cnt;
    i2c_req_nxt    = i2c_req_q;
    i2c_data_nxt   = i2c_data_q;
    grant_nxt      = grant_q;
    last_grant_nxt = last_grant;
    err_nxt        = err_q;
    case (state)
      ST_IDLE: begin
        if (any_req) grant_nxt = rr_pick(bus.req0_req, bus.req1_req, last_grant);
      end
      ST_LOAD: begin
        i2c_data_nxt = grant_q ? bus.req1_data : bus.req0_data;
        i2c_req_nxt  = 1'b1;
        tmo_cnt_nxt  = '0;
        err_nxt      = 1'b0;
      end
      ST_WAIT_ACK: begin
        tmo_cnt_nxt = tmo_cnt + 16'd1;
        if (bus.i2c_ack) begin
          i2c_req_nxt = 1'b0;
        end else if (tmo_hit) begin
          i2c_req_nxt = 1'b0;
          err_nxt     = 1'b1;
        end
      end
      ST_DROP: begin
        tmo_cnt_nxt = tmo_cnt + 16'd1;
        if (!bus.i2c_ack)  err_nxt = 1'b0;
        else if (tmo_hit)  err_nxt = 1'b1;
      end
      ST_DONE: begin
        if (!own_req) last_grant_nxt = grant_q;
      end
      default: ;
    endcase
  end

  assign bus.i2c_req  = i2c_req_q;
  assign bus.i2c_data = i2c_data_q;
  assign bus.busy     = (state != ST_IDLE);
  assign bus.grant    = grant_q;
  assign bus.req0_ack = (state == ST_DONE) && !grant_q;
  assign bus.req1_ack = (state == ST_DONE) &&  grant_q;
  assign bus.req0_err = bus.req0_ack && err_q;
  assign bus.req1_err = bus.req1_ack && err_q;

  ack_exclusive: assert property (@(posedge clk_25M) disable iff (rst_100)
    !(bus.req0_ack && bus.req1_ack));

endmodule

// File: tb/tb_i2c_arbiter.sv
// Scoreboard bench for i2c_arbiter: directed requester traffic against a behavioural send_i2c engine.
module tb_i2c_arbiter;
  import camera_pkg::*;

  typedef struct {
    logic        idx;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk_25M = 1'b0;
  logic rst_100 = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic mon_prev;
  int   eng_delay = 10;
  bit   eng_never = 1'b0;
  int   eng_cnt;
  int   hi_len;
  int   n;

  always #20 clk_25M = ~clk_25M;

  i2c_arbiter_if bus();

  i2c_arbiter #(.TIMEOUT_CYC(16'd100)) dut (
    .clk_25M (clk_25M),
    .rst_100 (rst_100),
    .bus     (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic idx, input logic [31:0] data, input logic err);
    exp_t e;
    e.idx  = idx;
    e.data = data;
    e.err  = err;
    sb.push_back(e);
  endtask

  task automatic raise(input logic idx, input logic [31:0] d);
    @(negedge clk_25M);
    if (idx) begin bus.req1_data = d; bus.req1_req = 1'b1; end
    else     begin bus.req0_data = d; bus.req0_req = 1'b1; end
  endtask

  // Hold req until the matching ack is seen, then release it on the same negedge.
  task automatic finish_req(input logic idx);
    int k = 0;
    while (!(idx ? bus.req1_ack : bus.req0_ack) && k < 2000) begin
      @(negedge clk_25M);
      k++;
    end
    chk(idx ? "ack1_wait" : "ack0_wait", (k >= 2000) ? 32'd1 : 32'd0, 32'd0);
    if (idx) bus.req1_req = 1'b0;
    else     bus.req0_req = 1'b0;
  endtask

  task automatic wait_i2c_req();
    int k = 0;
    while (!bus.i2c_req && k < 50) begin
      @(negedge clk_25M);
      k++;
    end
    chk("i2c_req_wait", (k >= 50) ? 32'd1 : 32'd0, 32'd0);
  endtask

  // Behavioural engine: ack eng_delay cycles after i2c_req, release once i2c_req drops.
  initial begin
    bus.i2c_ack = 1'b0;
    eng_cnt = 0;
    forever begin
      @(negedge clk_25M);
      if (rst_100) begin
        bus.i2c_ack = 1'b0;
        eng_cnt = 0;
      end else if (bus.i2c_ack) begin
        if (!bus.i2c_req) bus.i2c_ack = 1'b0;
      end else if (bus.i2c_req && !eng_never) begin
        if (eng_cnt >= eng_delay - 1) begin
          bus.i2c_ack = 1'b1;
          eng_cnt = 0;
        end else begin
          eng_cnt++;
        end
      end else begin
        eng_cnt = 0;
      end
    end
  end

  initial begin
    mon_prev = 1'b0;
    forever begin
      @(negedge clk_25M);
      if ((bus.req0_ack || bus.req1_ack) && !mon_prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("ack_owner", {31'd0, bus.req1_ack}, {31'd0, mon_e.idx});
          chk("grant",     {31'd0, bus.grant},    {31'd0, mon_e.idx});
          chk("err", {31'd0, mon_e.idx ? bus.req1_err : bus.req0_err}, {31'd0, mon_e.err});
          chk("i2c_data", bus.i2c_data, mon_e.data);
          chk("ack_overlap", {31'd0, bus.req0_ack && bus.req1_ack}, 32'd0);
        end
      end
      mon_prev = bus.req0_ack || bus.req1_ack;
    end
  end

  initial begin
    #(40 * 20000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req0_req = 1'b0; bus.req0_data = '0;
    bus.req1_req = 1'b0; bus.req1_data = '0;
    repeat (3) @(negedge clk_25M);
    chk("rst_i2c_req",  {31'd0, bus.i2c_req},  32'd0);
    chk("rst_i2c_data", bus.i2c_data,          32'd0);
    chk("rst_busy",     {31'd0, bus.busy},     32'd0);
    chk("rst_grant",    {31'd0, bus.grant},    32'd0);
    chk("rst_acks",     {30'd0, bus.req1_ack, bus.req0_ack}, 32'd0);
    chk("rst_errs",     {30'd0, bus.req1_err, bus.req0_err}, 32'd0);
    rst_100 = 1'b0;

    // Single requester, engine acks after 10 cycles; check the 2-cycle launch latency.
    push_exp(1'b0, 32'h78300882, 1'b0);
    raise(1'b0, 32'h78300882);
    @(negedge clk_25M);
    chk("lat_cycle1_i2c_req", {31'd0, bus.i2c_req}, 32'd0);
    chk("lat_cycle1_busy",    {31'd0, bus.busy},    32'd1);
    @(negedge clk_25M);
    chk("lat_cycle2_i2c_req", {31'd0, bus.i2c_req}, 32'd1);
    chk("lat_cycle2_data",    bus.i2c_data,         32'h78300882);
    finish_req(1'b0);

    // Simultaneous requests right after reset: requester 0 first.
    @(negedge clk_25M); rst_100 = 1'b1;
    @(negedge clk_25M); rst_100 = 1'b0;
    push_exp(1'b0, 32'h42001111, 1'b0);
    push_exp(1'b1, 32'h42002222, 1'b0);
    fork
      begin raise(1'b0, 32'h42001111); finish_req(1'b0); end
      begin raise(1'b1, 32'h42002222); finish_req(1'b1); end
    join

    // Continuous re-requests from both sides alternate ownership.
    push_exp(1'b0, 32'hA0000001, 1'b0);
    push_exp(1'b1, 32'hB0000002, 1'b0);
    push_exp(1'b0, 32'hA0000003, 1'b0);
    push_exp(1'b1, 32'hB0000004, 1'b0);
    fork
      begin
        raise(1'b0, 32'hA0000001); finish_req(1'b0);
        raise(1'b0, 32'hA0000003); finish_req(1'b0);
      end
      begin
        raise(1'b1, 32'hB0000002); finish_req(1'b1);
        raise(1'b1, 32'hB0000004); finish_req(1'b1);
      end
    join

    // Silent engine: i2c_req stays high exactly 100 cycles, then err is reported.
    eng_never = 1'b1;
    push_exp(1'b1, 32'h3C000A55, 1'b1);
    raise(1'b1, 32'h3C000A55);
    wait_i2c_req();
    hi_len = 0;
    while (bus.i2c_req && hi_len < 500) begin
      hi_len++;
      @(negedge clk_25M);
    end
    chk("timeout_len", hi_len, 32'd100);
    finish_req(1'b1);

    // Reset in WAIT_ACK aborts without an ack; the next transfer runs normally.
    raise(1'b0, 32'hDEADBEEF);
    wait_i2c_req();
    repeat (3) @(negedge clk_25M);
    rst_100 = 1'b1;
    bus.req0_req = 1'b0;
    @(negedge clk_25M);
    chk("abort_i2c_req", {31'd0, bus.i2c_req},  32'd0);
    chk("abort_busy",    {31'd0, bus.busy},     32'd0);
    chk("abort_ack",     {31'd0, bus.req0_ack}, 32'd0);
    rst_100 = 1'b0;
    eng_never = 1'b0;
    repeat (3) @(negedge clk_25M);
    chk("abort_idle", {31'd0, bus.busy}, 32'd0);
    push_exp(1'b0, 32'h12345678, 1'b0);
    raise(1'b0, 32'h12345678);
    finish_req(1'b0);

    // Owner withdraws during WAIT_ACK: transfer completes, ack is a 1-cycle pulse.
    push_exp(1'b1, 32'h5A5A0001, 1'b0);
    raise(1'b1, 32'h5A5A0001);
    wait_i2c_req();
    @(negedge clk_25M);
    bus.req1_req = 1'b0;
    n = 0;
    while (!bus.req1_ack && n < 200) begin
      @(negedge clk_25M);
      n++;
    end
    hi_len = 0;
    while (bus.req1_ack && hi_len < 10) begin
      hi_len++;
      @(negedge clk_25M);
    end
    chk("drop_ack_width", hi_len, 32'd1);

    repeat (20) @(negedge clk_25M);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16'd50000: maximum cycles a granted transfer may wait on i2c_ack in either phase.
REQ-002 SHALL have port clk_25M, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_100, input, 1, synchronous active-high reset.
REQ-004 SHALL have port req0_req, input, 1, requester 0 transfer request, held high until req0_ack.
REQ-005 SHALL have port req0_data, input, 32, requester 0 word {dev_addr[7:0], reg_addr[15:0], reg_val[7:0]}, stable while req0_req is high.
REQ-006 SHALL have port req0_ack, output, 1, requester 0 completion.
REQ-007 SHALL have port req0_err, output, 1, requester 0 timeout flag, valid while req0_ack is high.
REQ-008 SHALL have ports req1_req, req1_data, req1_ack and req1_err, identical to REQ-004..007, for requester 1.
REQ-009 SHALL have port i2c_req, output, 1, request to the shared send_i2c engine.
REQ-010 SHALL have port i2c_data, output, 32, word presented to the engine.
REQ-011 SHALL have port i2c_ack, input, 1, engine completion, synchronous to clk_25M.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-013 SHALL have port grant, output, 1, index of the current or most recent owner.

Function
REQ-014 SHALL implement the states IDLE, LOAD, WAIT_ACK, DROP and DONE.
REQ-015 SHALL transition IDLE->LOAD on the first cycle either reqN_req is high; grant is registered on that edge.
REQ-016 SHALL arbitrate round-robin: when both requesters are high, grant = !last_grant; when one is high, grant = that one.
REQ-017 SHALL, in LOAD, register i2c_data <= reqN_data[grant], set i2c_req <= 1, clear the timeout counter and go to WAIT_ACK; i2c_req rises 2 cycles after req is sampled in IDLE.
REQ-018 SHALL, in WAIT_ACK, on i2c_ack=1 set i2c_req <= 0 and go to DROP.
REQ-019 SHALL, in DROP, on i2c_ack=0 go to DONE with err=0.
REQ-020 SHALL increment the 16-bit timeout counter in WAIT_ACK and DROP; at TIMEOUT_CYC-1, force i2c_req <= 0 and go to DONE with err=1.
REQ-021 SHALL, in DONE, hold reqN_ack[grant]=1 and reqN_err[grant]=err until reqN_req[grant]=0, then clear both, update last_grant <= grant and return to IDLE.
REQ-022 SHALL, if the owner drops req before DONE, still complete the engine transfer; ack then pulses exactly 1 cycle in DONE.
REQ-023 SHALL hold the non-granted requester pending without ack; it wins the next arbitration.
REQ-024 SHALL hold i2c_data stable from LOAD until the next LOAD.
REQ-025 SHALL never assert both ack outputs in the same cycle.

Reset
REQ-026 SHALL, on rst_100=1 at a clock edge, force state=IDLE, i2c_req=0, i2c_data=0, req0_ack=req1_ack=0, req0_err=req1_err=0, busy=0, grant=0, last_grant=1 (requester 0 wins the first contention) and timeout counter=0.
REQ-027 SHALL, on reset during any state, abort the transfer and drop i2c_req on the same edge, without generating an ack.

Structure
REQ-028 SHALL take the state enum, I2C_WORD_W=32 and the TIMEOUT_CYC default from the shared package camera_pkg.
REQ-029 SHALL be a single module with no sub-module; the timeout counter and round-robin pointer are inline.

Verification
REQ-030 SHALL cover: req0 only, data 32'h78300882, engine acks 10 cycles after i2c_req -> i2c_data=32'h78300882, i2c_req high at cycle +2, req0_ack=1, req0_err=0.
REQ-031 SHALL cover: req0 and req1 rise on the same cycle after reset -> req0 served first, then req1; grant sequence 0,1.
REQ-032 SHALL cover: both requesters continuously re-requesting for 4 transfers -> grant alternates 0,1,0,1 and no ack overlap.
REQ-033 SHALL cover: engine never acks, TIMEOUT_CYC=100 -> i2c_req falls 100 cycles after entering WAIT_ACK, req1_ack=1, req1_err=1.
REQ-034 SHALL cover: rst_100 pulsed while in WAIT_ACK -> next cycle i2c_req=0, busy=0, no ack; a later req0 completes normally.
REQ-035 SHALL cover: req1 drops req while in WAIT_ACK -> transfer completes and req1_ack is high for exactly 1 cycle.
